// File: rtl/hyperbola_pkg.sv
// ============================================================================
// Module      : hyperbola_pkg
// Description : Shared types, iteration constants and the atanh(2^-k) table
//               for the hyperbolic CORDIC engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hyperbola_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        COMP = 2'd2,
        DONE = 2'd3
    } state_t;

    // Shift indices that must execute twice for hyperbolic convergence.
    localparam int REPEAT_A = 4;
    localparam int REPEAT_B = 13;

    // 1/K for the repeated-index sequence, and its Q17 shift-add encoding.
    localparam real    INV_GAIN       = 1.2074970677630726;
    localparam int     INV_GAIN_SHIFT = 17;
    localparam longint INV_GAIN_Q     = longint'(INV_GAIN * 131072.0);

    function automatic int n_steps(input int iter);
        n_steps = iter + ((iter >= REPEAT_A) ? 1 : 0) + ((iter >= REPEAT_B) ? 1 : 0);
    endfunction

    // atanh(2^-k); beyond k=12 the cubic term of the series is exact to double precision.
    function automatic real atanh_real(input int k);
        real x;
        case (k)
            1:       atanh_real = 0.5493061443340549;
            2:       atanh_real = 0.2554128118829954;
            3:       atanh_real = 0.1256572141404530;
            4:       atanh_real = 0.0625815714770030;
            5:       atanh_real = 0.0312601784906670;
            6:       atanh_real = 0.0156262717520522;
            7:       atanh_real = 0.0078126589515404;
            8:       atanh_real = 0.0039062698683968;
            9:       atanh_real = 0.0019531274835326;
            10:      atanh_real = 0.0009765628104410;
            11:      atanh_real = 0.0004882812888051;
            12:      atanh_real = 0.0002441406298506;
            default: begin
                x = 1.0;
                for (int i = 0; i < k; i++) x = x / 2.0;
                atanh_real = (k <= 0) ? 0.0 : x + (x * x * x) / 3.0;
            end
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/hyperbola_atanh_lut.sv
// ============================================================================
// Module      : hyperbola_atanh_lut
// Description : Combinational atanh(2^-k) table, rounded to FRAC_BITS bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hyperbola_atanh_lut
    import hyperbola_pkg::*;
#(
    parameter int W         = 18,
    parameter int FRAC_BITS = 16
) (
    input  logic [4:0]   i_k,
    output logic [W-1:0] o_angle
);

    localparam real c_scale = real'(64'd1 << FRAC_BITS);

    logic [W-1:0] w_table [32];

    generate
        for (genvar i = 0; i < 32; i++) begin : g_entry
            if (i == 0) begin : g_zero
                // atanh(1) is unbounded; index 0 is never issued.
                assign w_table[i] = '0;
            end else begin : g_val
                localparam longint c_val = longint'(atanh_real(i) * c_scale);
                assign w_table[i] = W'(c_val);
            end
        end
    endgenerate

    assign o_angle = w_table[i_k];

endmodule

`default_nettype wire

// File: rtl/hyperbola_cordic_rotator.sv
// ============================================================================
// Module      : hyperbola_cordic_rotator
// Description : Iterative hyperbolic CORDIC (rotation / vectoring) with
//               valid/ready handshakes. Define HYPERBOLA_GAIN_COMP_EN to add
//               a 1/K gain-compensation cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hyperbola_cordic_rotator
    import hyperbola_pkg::*;
#(
    parameter int DSIZE = 16,
    parameter int ITER  = 16,
    parameter int GUARD = 2
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [DSIZE-1:0] in_x,
    input  logic signed [DSIZE-1:0] in_y,
    input  logic signed [DSIZE-1:0] in_z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [DSIZE-1:0] out_x,
    output logic signed [DSIZE-1:0] out_y,
    output logic signed [DSIZE-1:0] out_z
);

    localparam int c_lut_w = DSIZE + GUARD;
    // Three headroom bits cover worst-case growth (x+y)*prod(1+2^-k) plus 1/K.
    localparam int c_iw    = DSIZE + GUARD + 3;

    localparam logic [5:0]          c_last_step = 6'(n_steps(ITER) - 1);
    localparam logic signed [c_iw:0] c_half     = (c_iw + 1)'((1 << GUARD) >> 1);
    localparam logic signed [c_iw:0] c_max      = (c_iw + 1)'((64'd1 << (DSIZE - 1)) - 64'd1);
    localparam logic signed [c_iw:0] c_min      = ~c_max;

    state_t                 r_state;
    logic                   r_mode;
    logic signed [c_iw-1:0] r_x;
    logic signed [c_iw-1:0] r_y;
    logic signed [c_iw-1:0] r_z;
    logic [5:0]             r_step;
    logic [4:0]             r_k;
    logic                   r_rep;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic signed [DSIZE-1:0] r_out_x;
    logic signed [DSIZE-1:0] r_out_y;
    logic signed [DSIZE-1:0] r_out_z;

    logic [c_lut_w-1:0]     w_angle;
    logic signed [c_iw-1:0] w_angle_ext;
    logic signed [c_iw-1:0] w_x_sh;
    logic signed [c_iw-1:0] w_y_sh;
    logic signed [c_iw-1:0] w_x_nxt;
    logic signed [c_iw-1:0] w_y_nxt;
    logic signed [c_iw-1:0] w_z_nxt;
    logic                   w_dir_pos;
    logic                   w_last_step;
    logic                   w_repeat;

    hyperbola_atanh_lut #(
        .W         (c_lut_w),
        .FRAC_BITS (DSIZE - 2 + GUARD)
    ) u_lut (
        .i_k     (r_k),
        .o_angle (w_angle)
    );

    always_comb begin
        w_angle_ext = c_iw'(w_angle);
        w_dir_pos   = r_mode ? r_y[c_iw-1] : ~r_z[c_iw-1];
        w_x_sh      = r_x >>> r_k;
        w_y_sh      = r_y >>> r_k;
        w_x_nxt     = w_dir_pos ? (r_x + w_y_sh) : (r_x - w_y_sh);
        w_y_nxt     = w_dir_pos ? (r_y + w_x_sh) : (r_y - w_x_sh);
        w_z_nxt     = w_dir_pos ? (r_z - w_angle_ext) : (r_z + w_angle_ext);
        w_last_step = (r_step == c_last_step);
        w_repeat    = ((r_k == 5'(REPEAT_A)) || (r_k == 5'(REPEAT_B))) && !r_rep;
    end

    // Round half-up at the guard boundary, then clamp to the output range.
    function automatic logic [DSIZE-1:0] round_sat(input logic signed [c_iw-1:0] v);
        logic signed [c_iw:0] t;
        t = (c_iw + 1)'(v);
        t = (t + c_half) >>> GUARD;
        if (t > c_max)
            t = c_max;
        else if (t < c_min)
            t = c_min;
        return t[DSIZE-1:0];
    endfunction

`ifdef HYPERBOLA_GAIN_COMP_EN
    localparam int                          c_acc_w     = c_iw + INV_GAIN_SHIFT + 2;
    localparam logic [INV_GAIN_SHIFT:0]     c_inv_q     = (INV_GAIN_SHIFT + 1)'(INV_GAIN_Q);
    localparam logic signed [c_acc_w-1:0]   c_comp_half = c_acc_w'(64'd1 << (INV_GAIN_SHIFT - 1));

    // Exact shift-add product with the Q17 constant, rounded once at the end.
    function automatic logic signed [c_iw-1:0] gain_comp(input logic signed [c_iw-1:0] v);
        logic signed [c_acc_w-1:0] ext;
        logic signed [c_acc_w-1:0] acc;
        ext = c_acc_w'(v);
        acc = '0;
        for (int b = 0; b <= INV_GAIN_SHIFT; b++) begin
            if (c_inv_q[b]) acc = acc + (ext <<< b);
        end
        acc = (acc + c_comp_half) >>> INV_GAIN_SHIFT;
        return acc[c_iw-1:0];
    endfunction
`endif

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_step      <= '0;
            r_k         <= '0;
            r_rep       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_z     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_x        <= c_iw'(in_x) <<< GUARD;
                        r_y        <= c_iw'(in_y) <<< GUARD;
                        r_z        <= c_iw'(in_z) <<< GUARD;
                        r_mode     <= in_mode;
                        r_step     <= '0;
                        r_k        <= 5'd1;
                        r_rep      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_x    <= w_x_nxt;
                    r_y    <= w_y_nxt;
                    r_z    <= w_z_nxt;
                    r_step <= r_step + 6'd1;
                    if (w_repeat) begin
                        r_rep <= 1'b1;
                    end else begin
                        r_k   <= r_k + 5'd1;
                        r_rep <= 1'b0;
                    end
                    if (w_last_step) begin
`ifdef HYPERBOLA_GAIN_COMP_EN
                        r_state <= COMP;
`else
                        r_state <= DONE;
`endif
                    end
                end
`ifdef HYPERBOLA_GAIN_COMP_EN
                COMP: begin
                    r_x     <= gain_comp(r_x);
                    r_y     <= gain_comp(r_y);
                    r_state <= DONE;
                end
`endif
                DONE: begin
                    // First DONE cycle registers the results; they then hold until taken.
                    if (!r_out_valid) begin
                        r_out_x     <= round_sat(r_x);
                        r_out_y     <= round_sat(r_y);
                        r_out_z     <= round_sat(r_z);
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_z     = r_out_z;

endmodule

`default_nettype wire

// File: tb/tb_hyperbola_cordic_rotator.sv
// ============================================================================
// Module      : tb_hyperbola_cordic_rotator
// Description : Directed self-checking bench for hyperbola_cordic_rotator
//               (main DSIZE=16/ITER=16 instance plus ITER=4 and ITER=13).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hyperbola_cordic_rotator;

`ifdef HYPERBOLA_GAIN_COMP_EN
    localparam int c_extra   = 1;
    localparam int c_rot_x   = 18475;
    localparam int c_rot_y   = 8538;
    localparam int c_vec_x   = 14189;
    localparam int c_edge_xy = 10713;
`else
    localparam int c_extra   = 0;
    localparam int c_rot_x   = 15300;
    localparam int c_rot_y   = 7070;
    localparam int c_vec_x   = 11751;
    localparam int c_edge_xy = 8872;
`endif
    localparam int c_tol = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_mode = 1'b0;
    logic signed [15:0] in_x = '0;
    logic signed [15:0] in_y = '0;
    logic signed [15:0] in_z = '0;
    logic               out_ready = 1'b1;
    logic               in_ready;
    logic               out_valid;
    logic signed [15:0] out_x, out_y, out_z;

    logic               v4 = 1'b0, v13 = 1'b0;
    logic               rdy4, rdy13, ov4, ov13;
    logic signed [15:0] x4, y4, z4, x13, y13, z13;

    hyperbola_cordic_rotator #(.DSIZE(16), .ITER(16), .GUARD(2)) dut (
        .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z)
    );

    hyperbola_cordic_rotator #(.DSIZE(16), .ITER(4), .GUARD(2)) dut4 (
        .clock(clock), .rst(rst), .in_valid(v4), .in_ready(rdy4),
        .in_mode(in_mode), .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(ov4), .out_ready(1'b1),
        .out_x(x4), .out_y(y4), .out_z(z4)
    );

    hyperbola_cordic_rotator #(.DSIZE(16), .ITER(13), .GUARD(2)) dut13 (
        .clock(clock), .rst(rst), .in_valid(v13), .in_ready(rdy13),
        .in_mode(in_mode), .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(ov13), .out_ready(1'b1),
        .out_x(x13), .out_y(y13), .out_z(z13)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
        n_tests++;
        if ((obs > exp + tol) || (obs < exp - tol)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one operand set, hold for the accepting edge, then scramble the inputs.
    task automatic start_op(input logic mode, input int x, input int y, input int z);
        int waited = 0;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        in_mode  = mode;
        in_x     = 16'(x);
        in_y     = 16'(y);
        in_z     = 16'(z);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_mode  = ~mode;
        in_x     = 16'sh5a5a;
        in_y     = -16'sd1234;
        in_z     = 16'sh2222;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 200);
    endtask

    initial begin
        int lat, lat4, lat13;
        int hx, hy, hz;
        bit stable, saw_ready;

        repeat (3) tick();
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_x", int'(out_x), 0);
        check("reset_out_y", int'(out_y), 0);
        check("reset_out_z", int'(out_z), 0);
        rst = 1'b0;
        tick();

        // Short-iteration builds: latency reveals N_STEPS (5 and 15).
        in_mode = 1'b1; in_x = 16'sd16384; in_y = 16'sd8192; in_z = '0;
        v4 = 1'b1; v13 = 1'b1;
        tick();
        v4 = 1'b0; v13 = 1'b0;
        lat4 = -1; lat13 = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (ov4 && lat4 < 0) lat4 = c;
            if (ov13 && lat13 < 0) begin
                lat13 = c;
                check("iter13_vec_z", int'(z13), 9000, c_tol);
            end
        end
        check("iter4_latency", lat4, 6 + c_extra);
        check("iter13_latency", lat13, 16 + c_extra);

        // Rotation: cosh/sinh(0.5).
        start_op(1'b0, 16384, 0, 8192);
        wait_result(lat);
        check("rot_latency", lat, 19 + c_extra);
        check("rot_x", int'(out_x), c_rot_x, c_tol);
        check("rot_y", int'(out_y), c_rot_y, c_tol);
        check("rot_z", int'(out_z), 0, c_tol);
        tick();

        // Vectoring: atanh(0.5), sqrt(1-0.25).
        start_op(1'b1, 16384, 8192, 0);
        wait_result(lat);
        check("vec_x", int'(out_x), c_vec_x, c_tol);
        check("vec_y", int'(out_y), 0, c_tol);
        check("vec_z", int'(out_z), 9000, c_tol);
        tick();

        // Downstream back-pressure for 10 cycles.
        out_ready = 1'b0;
        start_op(1'b0, 16384, 0, 8192);
        wait_result(lat);
        hx = int'(out_x); hy = int'(out_y); hz = int'(out_z);
        stable = 1'b1; saw_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!out_valid || int'(out_x) != hx || int'(out_y) != hy || int'(out_z) != hz)
                stable = 1'b0;
            if (in_ready) saw_ready = 1'b1;
        end
        check("hold_stable", int'(stable), 1);
        check("hold_in_ready_low", int'(saw_ready), 0);
        out_ready = 1'b1;
        tick();
        check("release_out_valid", int'(out_valid), 0);
        check("release_in_ready", int'(in_ready), 1);
        start_op(1'b1, 16384, 8192, 0);
        wait_result(lat);
        check("b2b_latency", lat, 19 + c_extra);
        check("b2b_x", int'(out_x), c_vec_x, c_tol);
        check("b2b_z", int'(out_z), 9000, c_tol);
        tick();

        // Reset during RUN at step 7.
        start_op(1'b0, 16384, 0, 8192);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_x", int'(out_x), 0);
        check("midrst_out_y", int'(out_y), 0);
        check("midrst_out_z", int'(out_z), 0);
        start_op(1'b0, 16384, 0, 8192);
        wait_result(lat);
        check("post_rst_x", int'(out_x), c_rot_x, c_tol);
        check("post_rst_y", int'(out_y), c_rot_y, c_tol);
        tick();

        // Edge of the rotation domain: x=y=~2.0, z=-1.118.
        start_op(1'b0, 32767, 32767, -18317);
        wait_result(lat);
        check("edge_x", int'(out_x), c_edge_xy, c_tol);
        check("edge_y", int'(out_y), c_edge_xy, c_tol);
        check("edge_z", int'(out_z), 0, c_tol);
        tick();

        // Far outside the domain: every step grows |x|,|y| to ~5.07, must clamp.
        start_op(1'b0, 32767, 32767, 32767);
        wait_result(lat);
        check("sat_pos_x", int'(out_x), 32767);
        check("sat_pos_y", int'(out_y), 32767);
        tick();
        start_op(1'b0, -32768, -32768, 32767);
        wait_result(lat);
        check("sat_neg_x", int'(out_x), -32768);
        check("sat_neg_y", int'(out_y), -32768);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
